// File: rtl/io_pin_select.sv
// io_pin_select: steers one peripheral function onto one of PINCOUNT pads.
// A move is break-before-make: every pad goes dark for 1+GUARD_CYCLES cycles.
// The receive path is synchronized and holds its last value while a move is in flight.
module io_pin_select #(
  parameter int PINCOUNT     = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int RESET_PIN    = 0,
  localparam int PWIDTH      = $clog2(PINCOUNT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel_valid,
  input  logic [PWIDTH-1:0]   pin_select,
  output logic                busy,
  output logic                sel_error,
  output logic [PWIDTH-1:0]   cur_pin,
  input  logic                func_oe,
  input  logic                func_transmit,
  output logic                func_receive,
  output logic [PINCOUNT-1:0] pin_ena,
  output logic [PINCOUNT-1:0] pin_out,
  input  logic [PINCOUNT-1:0] pin_in
);

  localparam int CWIDTH = $clog2(GUARD_CYCLES + 1);
  localparam logic [PWIDTH-1:0] RESET_IDX  = PWIDTH'(RESET_PIN);
  localparam logic [PWIDTH:0]   PIN_LIMIT  = (PWIDTH+1)'(PINCOUNT);
  localparam logic [CWIDTH-1:0] GUARD_LOAD = CWIDTH'(GUARD_CYCLES);

  // Bad parameter sets are caught at elaboration time.
  if (PINCOUNT < 2) begin : g_chk_pins
    $error("io_pin_select: PINCOUNT must be >= 2");
  end
  if (SYNC_STAGES < 1) begin : g_chk_sync
    $error("io_pin_select: SYNC_STAGES must be >= 1");
  end
  if (GUARD_CYCLES < SYNC_STAGES) begin : g_chk_guard
    $error("io_pin_select: GUARD_CYCLES must be >= SYNC_STAGES");
  end
  if (RESET_PIN >= PINCOUNT || RESET_PIN < 0) begin : g_chk_rst
    $error("io_pin_select: RESET_PIN out of range");
  end

  typedef enum logic [1:0] {ACTIVE, RELEASE, GUARD} state_t;

  state_t                 state_q, state_d;
  logic [CWIDTH-1:0]      guard_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   active;
  logic                   accept;
  logic                   sel_oor;
  logic                   move_ok;

  assign active  = (state_q == ACTIVE);
  assign busy    = ~active;
  assign accept  = active & sel_valid;
  assign sel_oor = ({1'b0, pin_select} >= PIN_LIMIT);
  // Same-pin requests are dropped so a no-op select never darkens the pad.
  assign move_ok = accept & ~sel_oor & (pin_select != cur_pin);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACTIVE;
    else     state_q <= state_d;
  end

  // Next state: ACTIVE -> RELEASE (1 cycle) -> GUARD (GUARD_CYCLES cycles) -> ACTIVE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACTIVE:  if (move_ok) state_d = RELEASE;
      RELEASE: state_d = GUARD;
      GUARD:   if (guard_cnt == CWIDTH'(1)) state_d = ACTIVE;
      default: state_d = ACTIVE;
    endcase
  end

  // Pin assignment, reject pulse and guard countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_pin   <= RESET_IDX;
      sel_error <= 1'b0;
      guard_cnt <= '0;
    end else begin
      sel_error <= accept & sel_oor;
      if (move_ok) cur_pin <= pin_select;
      if (state_q == RELEASE)    guard_cnt <= GUARD_LOAD;
      else if (state_q == GUARD) guard_cnt <= guard_cnt - CWIDTH'(1);
    end
  end

  // Synchronizer follows the assigned pin; it starts on the new pin during the
  // dark window so it is flushed of old-pin samples before ACTIVE resumes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= pin_in[cur_pin];
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Receive value updates only while ACTIVE; held across a move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         func_receive <= 1'b0;
    else if (active) func_receive <= sync_q[SYNC_STAGES-1];
  end

  // Per-pad drivers: only the assigned pad, and only while ACTIVE.
  for (genvar p = 0; p < PINCOUNT; p++) begin : g_pin
    logic here;
    assign here       = active & (cur_pin == PWIDTH'(p));
    assign pin_ena[p] = here & func_oe;
    assign pin_out[p] = here & func_oe & func_transmit;
  end

endmodule

// File: tb/tb_io_pin_select.sv
// Bench for io_pin_select: a 4-pin and a 5-pin instance share stimulus and are
// compared every cycle against a dark-countdown / sample-delay reference model,
// plus directed checks of move timing, rejects, receive hold and mid-move reset.
module tb_io_pin_select;
  localparam int G = 2;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_valid, func_oe, func_transmit;
  logic [1:0] psel4;
  logic [2:0] psel5;
  logic [3:0] pin_in4;
  logic [4:0] pin_in5;
  logic       busy4, err4, rx4, busy5, err5, rx5;
  logic [1:0] cur4;
  logic [2:0] cur5;
  logic [3:0] ena4, out4;
  logic [4:0] ena5, out5;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  io_pin_select #(.PINCOUNT(4), .GUARD_CYCLES(G), .SYNC_STAGES(S), .RESET_PIN(0)) dut4 (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .pin_select(psel4), .busy(busy4),
    .sel_error(err4), .cur_pin(cur4), .func_oe(func_oe), .func_transmit(func_transmit),
    .func_receive(rx4), .pin_ena(ena4), .pin_out(out4), .pin_in(pin_in4));

  io_pin_select #(.PINCOUNT(5), .GUARD_CYCLES(G), .SYNC_STAGES(S), .RESET_PIN(0)) dut5 (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .pin_select(psel5), .busy(busy5),
    .sel_error(err5), .cur_pin(cur5), .func_oe(func_oe), .func_transmit(func_transmit),
    .func_receive(rx5), .pin_ena(ena5), .pin_out(out5), .pin_in(pin_in5));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a pin index, a count of remaining dark cycles, and a
  // queue holding the last S samples of the assigned pin.
  int m_cur[2];
  int m_dark[2];
  bit m_err[2];
  bit m_rx[2];
  bit dq0[$];
  bit dq1[$];

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      m_cur[i] = 0; m_dark[i] = 0; m_err[i] = 0; m_rx[i] = 0;
    end
    dq0.delete(); dq1.delete();
    for (int k = 0; k < S; k++) begin dq0.push_back(1'b0); dq1.push_back(1'b0); end
  endfunction

  always @(posedge clk or posedge rst) begin
    int p, s;
    bit smp, oldest, act;
    if (rst) begin
      m_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        p   = (i == 0) ? 4 : 5;
        s   = (i == 0) ? int'(psel4) : int'(psel5);
        smp = (i == 0) ? pin_in4[m_cur[0]] : pin_in5[m_cur[1]];
        act = (m_dark[i] == 0);
        if (i == 0) begin oldest = dq0.pop_front(); dq0.push_back(smp); end
        else        begin oldest = dq1.pop_front(); dq1.push_back(smp); end
        if (act) m_rx[i] = oldest;
        m_err[i] = act && sel_valid && (s >= p);
        if (!act) m_dark[i] = m_dark[i] - 1;
        else if (sel_valid && s < p && s != m_cur[i]) begin
          m_cur[i]  = s;
          m_dark[i] = 1 + G;
        end
      end
    end
  end

  function automatic int exp_pad(input int i, input bit v);
    return (m_dark[i] == 0 && v) ? (1 << m_cur[i]) : 0;
  endfunction

  task automatic check_all();
    chk("busy4", busy4, m_dark[0] > 0);
    chk("cur4",  cur4,  m_cur[0]);
    chk("err4",  err4,  m_err[0]);
    chk("rx4",   rx4,   m_rx[0]);
    chk("ena4",  ena4,  exp_pad(0, func_oe));
    chk("out4",  out4,  exp_pad(0, func_oe & func_transmit));
    chk("busy5", busy5, m_dark[1] > 0);
    chk("cur5",  cur5,  m_cur[1]);
    chk("err5",  err5,  m_err[1]);
    chk("rx5",   rx5,   m_rx[1]);
    chk("ena5",  ena5,  exp_pad(1, func_oe));
    chk("out5",  out5,  exp_pad(1, func_oe & func_transmit));
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1; sel_valid = 1'b0; psel4 = '0; psel5 = '0;
    func_oe = 1'b1; func_transmit = 1'b1; pin_in4 = '0; pin_in5 = '0;

    // Reset state with the function driving high.
    cyc();
    chk("rst_cur4", cur4, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_ena4", ena4, 4'b0001);
    chk("rst_out4", out4, 4'b0001);
    rst = 1'b0;
    cyc();

    // Move 0 -> 2: three dark cycles, cur_pin updated from the accepting edge.
    sel_valid = 1'b1; psel4 = 2'd2;
    for (int k = 0; k < 3; k++) begin
      cyc();
      sel_valid = 1'b0;
      chk("mv_busy", busy4, 1);
      chk("mv_ena", ena4, 0);
      chk("mv_cur", cur4, 2);
    end
    cyc();
    chk("mv_busy_end", busy4, 0);
    chk("mv_ena_end", ena4, 4'b0100);
    chk("mv_out_end", out4, 4'b0100);

    // Out-of-range on the 5-pin part, same-pin on the 4-pin part.
    sel_valid = 1'b1; psel4 = 2'd2; psel5 = 3'd5;
    cyc();
    sel_valid = 1'b0;
    chk("oor_err5", err5, 1);
    chk("oor_busy5", busy5, 0);
    chk("oor_cur5", cur5, 0);
    chk("same_err4", err4, 0);
    chk("same_busy4", busy4, 0);
    chk("same_ena4", ena4, 4'b0100);
    cyc();
    chk("oor_err5_end", err5, 0);
    psel5 = 3'd0;

    // Receive hold across a move 1 -> 3.
    pin_in4 = 4'b0010; sel_valid = 1'b1; psel4 = 2'd1;
    cyc();
    sel_valid = 1'b0;
    repeat (6) cyc();
    chk("rx_on1", rx4, 1);
    sel_valid = 1'b1; psel4 = 2'd3;
    for (int k = 0; k < 4; k++) begin
      cyc();
      sel_valid = 1'b0;
      chk("rx_hold", rx4, 1);
    end
    cyc();
    chk("rx_new", rx4, 0);

    // Reset mid-GUARD after 0 -> 3; a request while busy is dropped.
    rst = 1'b1; #1; check_all();
    cyc();
    rst = 1'b0;
    psel4 = 2'd3; sel_valid = 1'b1;
    cyc();
    sel_valid = 1'b0;
    cyc();
    sel_valid = 1'b1; psel4 = 2'd1;
    cyc();
    sel_valid = 1'b0;
    chk("drop_cur", cur4, 3);
    chk("drop_busy", busy4, 1);
    func_oe = 1'b0; rst = 1'b1;
    #1;
    chk("rg_busy", busy4, 0);
    chk("rg_cur", cur4, 0);
    chk("rg_ena", ena4, 0);
    chk("rg_out", out4, 0);
    chk("rg_rx", rx4, 0);
    chk("rg_err", err4, 0);
    check_all();
    cyc();
    rst = 1'b0; func_oe = 1'b1;

    // Randomized traffic with occasional asynchronous resets.
    repeat (800) begin
      cyc();
      rst = ($urandom_range(0, 63) == 0);
      sel_valid = ($urandom_range(0, 3) == 0);
      psel4 = 2'($urandom_range(0, 3));
      psel5 = 3'($urandom_range(0, 7));
      func_oe = 1'($urandom_range(0, 1));
      func_transmit = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        pin_in4 = 4'($urandom_range(0, 15));
        pin_in5 = 5'($urandom_range(0, 31));
      end
      if (rst) begin #1; check_all(); end
    end
    rst = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
